sparc_mem_ctrl: RTL and testbench

SPARC_MEM_CTRL -- requirements
Module: sparc_mem_ctrl

---
 rtl/sparc_mem_ctrl_if.sv | 37 +++
 rtl/sparc_mem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_sparc_mem_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sparc_mem_ctrl_if.sv
// sparc_mem_ctrl_if
// Bus between a CPU-side requester and the sparc_mem_ctrl memory block.
// The requester drives:
//   Enable, RW, OpCode, SignedLd, MAR_Address, MDR_DataIn
// The controller returns:
//   MDR_DataOut  registered load data
//   MFC          memory-function-complete pulse
//   MAE          address error, qualified by MFC
//   Busy         access in progress
// Modports:
//   master  the requester side
//   slave   the controller side
`timescale 1ns/1ps
interface sparc_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              Enable;
  logic              RW;
  logic [1:0]        OpCode;
  logic              SignedLd;
  logic [ADDR_W-1:0] MAR_Address;
  logic [31:0]       MDR_DataIn;
  logic [31:0]       MDR_DataOut;
  logic              MFC;
  logic              MAE;
  logic              Busy;

  modport master (
    output Enable, RW, OpCode, SignedLd, MAR_Address, MDR_DataIn,
    input  MDR_DataOut, MFC, MAE, Busy
  );

  modport slave (
    input  Enable, RW, OpCode, SignedLd, MAR_Address, MDR_DataIn,
    output MDR_DataOut, MFC, MAE, Busy
  );
endinterface

// File: rtl/sparc_mem_ctrl.sv
// sparc_mem_ctrl
// Byte-addressed, big-endian memory with a fixed number of wait states.
// Supports byte, halfword and word loads and stores. Byte and halfword
// loads are sign- or zero-extended. Misaligned accesses report MAE and
// leave both memory and MDR_DataOut untouched.
//
// Parameters:
//   DEPTH_BYTES  memory size in bytes (power of two, >= 8)
//   WAIT_STATES  extra cycles per access (0..15)
//   ADDR_W       width of MAR_Address
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; memory contents are kept
//   bus    sparc_mem_ctrl_if.slave request/response bus
//
// Timing: the request is accepted on the edge that sees Enable in IDLE.
// WAIT_STATES cycles are spent in WAIT, then one cycle in DONE. Store
// commit and load capture happen on the edge entering DONE. MFC/MAE are
// registered out of DONE, so they pulse WAIT_STATES+1 edges after
// acceptance.
`timescale 1ns/1ps
module sparc_mem_ctrl #(
  parameter int DEPTH_BYTES = 512,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  sparc_mem_ctrl_if.slave  bus
);

  localparam int         AW      = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;

  logic        rw_q, sgn_q;
  logic [1:0]  op_q;
  logic [AW-1:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mdr_q;
  logic        mfc_q, mae_q;

  logic [7:0]  mem [DEPTH_BYTES];

  // Only the low AW address bits select a byte; the rest alias.
  logic [ADDR_W-1:0] addr_in;
  logic              unused_addr_hi;
  assign addr_in        = bus.MAR_Address;
  assign unused_addr_hi = ^addr_in[ADDR_W-1:AW];

  logic accept;
  assign accept = (state == IDLE) && bus.Enable;

  // With zero wait states the accepting edge is also the edge entering
  // DONE, before the latched copies exist, so use the live bus in IDLE.
  logic          rw_e, sgn_e;
  logic [1:0]    op_e;
  logic [AW-1:0] addr_e;
  logic [31:0]   wdata_e;
  assign rw_e    = (state == IDLE) ? bus.RW            : rw_q;
  assign sgn_e   = (state == IDLE) ? bus.SignedLd      : sgn_q;
  assign op_e    = (state == IDLE) ? bus.OpCode        : op_q;
  assign addr_e  = (state == IDLE) ? addr_in[AW-1:0]   : addr_q;
  assign wdata_e = (state == IDLE) ? bus.MDR_DataIn    : wdata_q;

  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (op_e)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_e[0];
      2'b10:   misaligned = |addr_e[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Reset on the same edge cancels the commit, which aborts the access.
  logic commit;
  assign commit = rst_n && (state_nxt == DONE) && !misaligned;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept)
        wait_cnt <= 4'd0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Enable) state_nxt = (WAIT_STATES == 0) ? DONE : WAIT;
      WAIT:    if (wait_cnt == WS_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance so the requester may move on.
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q    <= bus.RW;
      sgn_q   <= bus.SignedLd;
      op_q    <= bus.OpCode;
      addr_q  <= addr_in[AW-1:0];
      wdata_q <= bus.MDR_DataIn;
    end
  end

  // Big-endian lane addresses; aligned accesses never carry across lanes.
  logic [AW-1:0] a_h0, a_h1, a_w0, a_w1, a_w2, a_w3;
  assign a_h0 = {addr_e[AW-1:1], 1'b0};
  assign a_h1 = {addr_e[AW-1:1], 1'b1};
  assign a_w0 = {addr_e[AW-1:2], 2'b00};
  assign a_w1 = {addr_e[AW-1:2], 2'b01};
  assign a_w2 = {addr_e[AW-1:2], 2'b10};
  assign a_w3 = {addr_e[AW-1:2], 2'b11};

  logic [31:0] load_val;
  always_comb begin
    load_val = 32'd0;
    case (op_e)
      2'b00:   load_val = {{24{sgn_e & mem[addr_e][7]}}, mem[addr_e]};
      2'b01:   load_val = {{16{sgn_e & mem[a_h0][7]}}, mem[a_h0], mem[a_h1]};
      2'b10:   load_val = {mem[a_w0], mem[a_w1], mem[a_w2], mem[a_w3]};
      default: load_val = 32'd0;
    endcase
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit && !rw_e) begin
      case (op_e)
        2'b00: mem[addr_e] <= wdata_e[7:0];
        2'b01: begin
          mem[a_h0] <= wdata_e[15:8];
          mem[a_h1] <= wdata_e[7:0];
        end
        2'b10: begin
          mem[a_w0] <= wdata_e[31:24];
          mem[a_w1] <= wdata_e[23:16];
          mem[a_w2] <= wdata_e[15:8];
          mem[a_w3] <= wdata_e[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdr_q <= 32'd0;
      mfc_q <= 1'b0;
      mae_q <= 1'b0;
    end else begin
      if (commit && rw_e)
        mdr_q <= load_val;
      mfc_q <= (state == DONE);
      mae_q <= (state == DONE) && misaligned;
    end
  end

  assign bus.MDR_DataOut = mdr_q;
  assign bus.MFC         = mfc_q;
  assign bus.MAE         = mae_q;
  assign bus.Busy        = (state != IDLE);

endmodule

// File: tb/tb_sparc_mem_ctrl.sv
// tb_sparc_mem_ctrl
// Directed bench for sparc_mem_ctrl. dut0 uses WAIT_STATES=2 for the
// functional vectors; dut1 uses WAIT_STATES=0 for back-to-back throughput.
`timescale 1ns/1ps
module tb_sparc_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sparc_mem_ctrl_if #(.ADDR_W(32)) bus0 ();
  sparc_mem_ctrl_if #(.ADDR_W(32)) bus1 ();

  sparc_mem_ctrl #(.DEPTH_BYTES(512), .WAIT_STATES(2), .ADDR_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  sparc_mem_ctrl #(.DEPTH_BYTES(512), .WAIT_STATES(0), .ADDR_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int   vecCount  = 0;
  int   missCount = 0;
  int   edges;
  logic mae;
  logic [7:0] mfcVec, busyVec;

  // One comparison: counted, and reported with tag/observed/expected on miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One access on dut0. Inputs are scrambled right after acceptance so a
  // controller that fails to latch them gets caught. Returns the number of
  // edges from acceptance to the first MFC sample, and MAE at that point.
  task automatic applyStimulus(input logic rw, input logic [1:0] op,
                               input logic sgn, input logic [31:0] addr,
                               input logic [31:0] data,
                               output int edgeCount, output logic maeOut);
    bus0.Enable      = 1'b1;
    bus0.RW          = rw;
    bus0.OpCode      = op;
    bus0.SignedLd    = sgn;
    bus0.MAR_Address = addr;
    bus0.MDR_DataIn  = data;
    @(posedge clk); #1;
    bus0.Enable      = 1'b0;
    bus0.RW          = ~rw;
    bus0.OpCode      = 2'($urandom);
    bus0.SignedLd    = ~sgn;
    bus0.MAR_Address = $urandom;
    bus0.MDR_DataIn  = $urandom;
    checkOutput("busy_after_accept", bus0.Busy, 1);
    edgeCount = 0;
    maeOut    = 1'b0;
    while (edgeCount < 20) begin
      @(posedge clk); #1;
      edgeCount++;
      if (bus0.MFC) begin
        maeOut = bus0.MAE;
        break;
      end
    end
    if (!bus0.MFC) checkOutput("mfc_timeout", bus0.MFC, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus0.Enable = 1'b0; bus0.RW = 1'b0; bus0.OpCode = 2'b00; bus0.SignedLd = 1'b0;
    bus0.MAR_Address = '0; bus0.MDR_DataIn = '0;
    bus1.Enable = 1'b0; bus1.RW = 1'b0; bus1.OpCode = 2'b00; bus1.SignedLd = 1'b0;
    bus1.MAR_Address = '0; bus1.MDR_DataIn = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_mfc",  bus0.MFC, 0);
    checkOutput("reset_mae",  bus0.MAE, 0);
    checkOutput("reset_busy", bus0.Busy, 0);
    checkOutput("reset_mdr",  bus0.MDR_DataOut, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then loads, big-endian byte lanes.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, edges, mae);
    checkOutput("store_w_latency", edges, 3);
    checkOutput("store_w_mae", mae, 0);
    @(posedge clk); #1;
    checkOutput("mfc_one_cycle", bus0.MFC, 0);
    checkOutput("store_keeps_mdr", bus0.MDR_DataOut, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, edges, mae);
    checkOutput("load_w_10", bus0.MDR_DataOut, 32'hDEADBEEF);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h10, 32'h0, edges, mae);
    checkOutput("load_b_10", bus0.MDR_DataOut, 32'h000000DE);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h13, 32'h0, edges, mae);
    checkOutput("load_b_13", bus0.MDR_DataOut, 32'h000000EF);

    // Sign extension.
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h21, 32'h12345680, edges, mae);
    applyStimulus(1'b1, 2'b00, 1'b1, 32'h21, 32'h0, edges, mae);
    checkOutput("load_b_21_signed", bus0.MDR_DataOut, 32'hFFFFFF80);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h21, 32'h0, edges, mae);
    checkOutput("load_b_21_unsigned", bus0.MDR_DataOut, 32'h00000080);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h22, 32'h00008001, edges, mae);
    applyStimulus(1'b1, 2'b01, 1'b1, 32'h22, 32'h0, edges, mae);
    checkOutput("load_h_22_signed", bus0.MDR_DataOut, 32'hFFFF8001);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h21, 32'h0, edges, mae);
    checkOutput("neighbour_byte_kept", bus0.MDR_DataOut, 32'h00000080);

    // Misalignment.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h04, 32'h11223344, edges, mae);
    checkOutput("aligned_store_mae", mae, 0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h06, 32'hCAFEF00D, edges, mae);
    checkOutput("misaligned_store_mae", mae, 1);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h04, 32'h0, edges, mae);
    checkOutput("mem_04_unchanged", bus0.MDR_DataOut, 32'h11223344);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h03, 32'h0, edges, mae);
    checkOutput("misaligned_load_mae", mae, 1);
    checkOutput("misaligned_load_mdr", bus0.MDR_DataOut, 32'h11223344);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, edges, mae);
    checkOutput("reserved_op_mae", mae, 1);
    checkOutput("reserved_op_mdr", bus0.MDR_DataOut, 32'h11223344);

    // Address wrap-around.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h204, 32'h12345678, edges, mae);
    checkOutput("wrap_store_mae", mae, 0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h004, 32'h0, edges, mae);
    checkOutput("wrap_load_004", bus0.MDR_DataOut, 32'h12345678);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'hFFFFFE04, 32'h0, edges, mae);
    checkOutput("wrap_load_high_bits", bus0.MDR_DataOut, 32'h12345678);

    // Reset during WAIT aborts the store.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h08, 32'h55667788, edges, mae);
    bus0.Enable = 1'b1; bus0.RW = 1'b0; bus0.OpCode = 2'b10;
    bus0.MAR_Address = 32'h08; bus0.MDR_DataIn = 32'hAAAAAAAA;
    @(posedge clk); #1;
    bus0.Enable = 1'b0;
    checkOutput("abort_busy_in_wait", bus0.Busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("abort_busy_cleared", bus0.Busy, 0);
    checkOutput("abort_mdr_cleared", bus0.MDR_DataOut, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("abort_no_mfc", bus0.MFC, 0);
      @(posedge clk); #1;
    end
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h08, 32'h0, edges, mae);
    checkOutput("abort_mem_kept", bus0.MDR_DataOut, 32'h55667788);

    // Reset wins over Enable on the same edge.
    rst_n = 1'b0;
    bus0.Enable = 1'b1; bus0.RW = 1'b1; bus0.OpCode = 2'b10; bus0.MAR_Address = 32'h10;
    @(posedge clk); #1;
    checkOutput("reset_priority_busy", bus0.Busy, 0);
    bus0.Enable = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_priority_idle", bus0.Busy, 0);

    // Back-to-back on dut1: Enable held for exactly three accesses.
    bus1.RW = 1'b0; bus1.OpCode = 2'b10; bus1.MAR_Address = 32'h0;
    bus1.MDR_DataIn = 32'h0BADCAFE; bus1.Enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      mfcVec[i]  = bus1.MFC;
      busyVec[i] = bus1.Busy;
      if (i == 5) bus1.Enable = 1'b0;
    end
    checkOutput("b2b_mfc_pattern",  {24'h0, mfcVec},  32'h0000002A);
    checkOutput("b2b_busy_pattern", {24'h0, busyVec}, 32'h00000015);
    bus1.RW = 1'b1; bus1.Enable = 1'b1;
    @(posedge clk); #1;
    bus1.Enable = 1'b0;
    @(posedge clk); #1;
    checkOutput("ws0_load_mfc", bus1.MFC, 1);
    checkOutput("ws0_load_data", bus1.MDR_DataOut, 32'h0BADCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
